// File: rtl/simd_sat_addsub_pipe_pkg.sv
// Shared definitions for the packed-SIMD saturating add/sub pipeline.
package simd_sat_addsub_pipe_pkg;

  // Operation encodings applied uniformly to every lane
  typedef enum logic [1:0] {
    OP_ADD_WRAP = 2'b00,
    OP_ADD_SSAT = 2'b01,
    OP_ADD_USAT = 2'b10,
    OP_SUB_SSAT = 2'b11
  } op_e;

  // Subtraction is done as A + ~B + 1, so the adder only needs to know this bit
  function automatic logic op_is_sub(input op_e op);
    return (op == OP_SUB_SSAT);
  endfunction

endpackage

// File: rtl/simd_sat_addsub_pipe_sat_lane.sv
// Combinational saturation of one lane: turns a raw (LANE_W+1)-bit sum into
// the final lane result and its "saturated" flag according to the operation.
module sat_lane
  import simd_sat_addsub_pipe_pkg::*;
#(
  parameter int LANE_W = 8
) (
  input  logic [LANE_W:0]   raw,
  input  logic              a_sgn,
  input  logic              b_sgn,
  input  op_e               op,
  output logic [LANE_W-1:0] res,
  output logic              ovf
);

  localparam logic [LANE_W-1:0] LANE_SMAX = {1'b0, {(LANE_W-1){1'b1}}};
  localparam logic [LANE_W-1:0] LANE_SMIN = {1'b1, {(LANE_W-1){1'b0}}};
  localparam logic [LANE_W-1:0] LANE_UMAX = {LANE_W{1'b1}};

  // Signed clamp direction follows the A operand sign: positive overflow -> max
  function automatic logic [LANE_W-1:0] sat_signed(input logic sgn);
    return sgn ? LANE_SMIN : LANE_SMAX;
  endfunction

  logic s_ovf;
  logic u_ovf;

  // Overflow detection: like-signed operands yielding an unlike-signed result,
  // or a carry out of the lane for unsigned arithmetic
  assign s_ovf = (a_sgn == b_sgn) && (raw[LANE_W-1] != a_sgn);
  assign u_ovf = raw[LANE_W];

  // Select result and flag by operation
  always_comb begin
    res = raw[LANE_W-1:0];
    ovf = 1'b0;
    case (op)
      OP_ADD_SSAT, OP_SUB_SSAT: begin
        if (s_ovf) begin
          res = sat_signed(a_sgn);
          ovf = 1'b1;
        end
      end
      OP_ADD_USAT: begin
        if (u_ovf) begin
          res = LANE_UMAX;
          ovf = 1'b1;
        end
      end
      default: begin
        res = raw[LANE_W-1:0];
        ovf = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/simd_sat_addsub_pipe.sv
// Two-stage packed-SIMD add/subtract with per-lane saturation and a
// valid/ready handshake on both sides. Stage 1 holds the raw lane sums,
// stage 2 holds the saturated result presented on Sum/ovf.
module simd_sat_addsub_pipe
  import simd_sat_addsub_pipe_pkg::*;
#(
  parameter int LANE_W = 8,
  parameter int LANES  = 2,
  localparam int W     = LANE_W * LANES
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [1:0]       op,
  input  logic [W-1:0]     A,
  input  logic [W-1:0]     B,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [W-1:0]     Sum,
  output logic [LANES-1:0] ovf,
  output logic [LANES-1:0] ovf_sticky,
  input  logic             clr_sticky
);

  op_e              op_c;
  logic             sub_c;
  logic             adv;
  logic             take;
  logic [LANE_W:0]  raw_c [LANES];
  logic [LANES-1:0] a_sgn_c;
  logic [LANES-1:0] b_sgn_c;

  logic             vld_p1;
  op_e              op_p1;
  logic [LANE_W:0]  raw_p1 [LANES];
  logic [LANES-1:0] a_sgn_p1;
  logic [LANES-1:0] b_sgn_p1;

  logic [W-1:0]     res_c;
  logic [LANES-1:0] ovf_c;

  assign op_c     = op_e'(op);
  assign sub_c    = op_is_sub(op_c);
  // The whole pipe moves in lockstep: it advances whenever the output slot is free or draining
  assign adv      = !out_valid | out_ready;
  assign in_ready = adv;
  assign take     = in_valid & adv;

  for (genvar i = 0; i < LANES; i++) begin : g_lane
    logic [LANE_W-1:0] a_l;
    logic [LANE_W-1:0] b_eff;

    // Per-lane adder; carry-in only for subtraction, no carry crosses lanes
    assign a_l        = A[i*LANE_W +: LANE_W];
    assign b_eff      = B[i*LANE_W +: LANE_W] ^ {LANE_W{sub_c}};
    assign raw_c[i]   = {1'b0, a_l} + {1'b0, b_eff} + (LANE_W+1)'(sub_c);
    assign a_sgn_c[i] = a_l[LANE_W-1];
    assign b_sgn_c[i] = b_eff[LANE_W-1];

    sat_lane #(.LANE_W(LANE_W)) u_sat (
      .raw   (raw_p1[i]),
      .a_sgn (a_sgn_p1[i]),
      .b_sgn (b_sgn_p1[i]),
      .op    (op_p1),
      .res   (res_c[i*LANE_W +: LANE_W]),
      .ovf   (ovf_c[i])
    );
  end

  // ---- Stage 1: raw lane sums, operand signs and op ----
  // Data is reset too so no X can ever reach Sum through a bubble
  always_ff @(posedge clk) begin
    if (rst) begin
      vld_p1   <= 1'b0;
      op_p1    <= OP_ADD_WRAP;
      raw_p1   <= '{default: '0};
      a_sgn_p1 <= '0;
      b_sgn_p1 <= '0;
    end else if (adv) begin
      vld_p1   <= take;
      op_p1    <= op_c;
      raw_p1   <= raw_c;
      a_sgn_p1 <= a_sgn_c;
      b_sgn_p1 <= b_sgn_c;
    end
  end

  // ---- Stage 2: saturated result register, held while the consumer stalls ----
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      Sum       <= '0;
      ovf       <= '0;
    end else if (adv) begin
      out_valid <= vld_p1;
      Sum       <= res_c;
      ovf       <= ovf_c;
    end
  end

  // Sticky status: a flag from an accepted beat wins over a same-cycle clear
  always_ff @(posedge clk) begin
    if (rst) begin
      ovf_sticky <= '0;
    end else begin
      ovf_sticky <= (clr_sticky ? '0 : ovf_sticky) |
                    ((out_valid & out_ready) ? ovf : '0);
    end
  end

endmodule

// File: tb/tb_simd_sat_addsub_pipe.sv
// Directed bench for simd_sat_addsub_pipe: a default 2x8-bit instance and a
// 4x16-bit instance share clock and reset.
module tb_simd_sat_addsub_pipe;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst;

  logic        n_in_valid, n_in_ready, n_out_valid, n_out_ready, n_clr;
  logic [1:0]  n_op;
  logic [15:0] n_a, n_b, n_sum;
  logic [1:0]  n_ovf, n_sticky;

  logic        w_in_valid, w_in_ready, w_out_valid, w_out_ready, w_clr;
  logic [1:0]  w_op;
  logic [63:0] w_a, w_b, w_sum;
  logic [3:0]  w_ovf, w_sticky;

  int checks = 0;
  int passed = 0;

  simd_sat_addsub_pipe #(.LANE_W(8), .LANES(2)) dut_n (
    .clk(clk), .rst(rst), .in_valid(n_in_valid), .in_ready(n_in_ready), .op(n_op),
    .A(n_a), .B(n_b), .out_valid(n_out_valid), .out_ready(n_out_ready), .Sum(n_sum),
    .ovf(n_ovf), .ovf_sticky(n_sticky), .clr_sticky(n_clr)
  );

  simd_sat_addsub_pipe #(.LANE_W(16), .LANES(4)) dut_w (
    .clk(clk), .rst(rst), .in_valid(w_in_valid), .in_ready(w_in_ready), .op(w_op),
    .A(w_a), .B(w_b), .out_valid(w_out_valid), .out_ready(w_out_ready), .Sum(w_sum),
    .ovf(w_ovf), .ovf_sticky(w_sticky), .clr_sticky(w_clr)
  );

  task automatic issue_n(input logic [1:0] o, input logic [15:0] a, input logic [15:0] b);
    n_op = o; n_a = a; n_b = b; n_in_valid = 1'b1;
    @(negedge clk);
    n_in_valid = 1'b0;
  endtask

  task automatic issue_w(input logic [1:0] o, input logic [63:0] a, input logic [63:0] b);
    w_op = o; w_a = a; w_b = b; w_in_valid = 1'b1;
    @(negedge clk);
    w_in_valid = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    n_out_ready = 1'b0;
    w_out_ready = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    checks++; if (n_out_valid !== 1'b0) $display("FAIL reset_out_valid got %b want 0", n_out_valid); else passed++;
    checks++; if (n_sum !== 16'h0000) $display("FAIL reset_sum got %h want 0000", n_sum); else passed++;
    checks++; if (n_ovf !== 2'b00) $display("FAIL reset_ovf got %b want 00", n_ovf); else passed++;
    checks++; if (n_sticky !== 2'b00) $display("FAIL reset_sticky got %b want 00", n_sticky); else passed++;
    checks++; if (n_in_ready !== 1'b1) $display("FAIL reset_in_ready got %b want 1", n_in_ready); else passed++;
    checks++; if (w_out_valid !== 1'b0 || w_sum !== 64'h0) $display("FAIL reset_wide got v=%b s=%h want v=0 s=0", w_out_valid, w_sum); else passed++;
  endtask

  task automatic test_add_ssat();
    n_out_ready = 1'b1;
    issue_n(2'b01, 16'h7F80, 16'h0180);
    checks++; if (n_out_valid !== 1'b0) $display("FAIL ssat_latency1 got %b want 0", n_out_valid); else passed++;
    @(negedge clk);
    checks++; if (n_out_valid !== 1'b1) $display("FAIL ssat_valid got %b want 1", n_out_valid); else passed++;
    checks++; if (n_sum !== 16'h7F80) $display("FAIL ssat_sum got %h want 7f80", n_sum); else passed++;
    checks++; if (n_ovf !== 2'b11) $display("FAIL ssat_ovf got %b want 11", n_ovf); else passed++;
    @(negedge clk);
    checks++; if (n_sticky !== 2'b11) $display("FAIL ssat_sticky got %b want 11", n_sticky); else passed++;
    checks++; if (n_out_valid !== 1'b0) $display("FAIL ssat_single_beat got %b want 0", n_out_valid); else passed++;
  endtask

  task automatic test_usat_wrap();
    n_out_ready = 1'b1;
    issue_n(2'b10, 16'hF001, 16'h2002);
    @(negedge clk);
    checks++; if (n_sum !== 16'hFF03 || n_ovf !== 2'b10) $display("FAIL usat got %h/%b want ff03/10", n_sum, n_ovf); else passed++;
    issue_n(2'b00, 16'hF001, 16'h2002);
    @(negedge clk);
    checks++; if (n_sum !== 16'h1003 || n_ovf !== 2'b00) $display("FAIL wrap got %h/%b want 1003/00", n_sum, n_ovf); else passed++;
  endtask

  task automatic test_sub_ssat();
    n_out_ready = 1'b1;
    issue_n(2'b11, 16'h8005, 16'h0107);
    @(negedge clk);
    checks++; if (n_sum !== 16'h80FE || n_ovf !== 2'b10) $display("FAIL sub_ssat got %h/%b want 80fe/10", n_sum, n_ovf); else passed++;
    issue_n(2'b11, 16'h0500, 16'h0300);
    @(negedge clk);
    checks++; if (n_sum !== 16'h0200 || n_ovf !== 2'b00) $display("FAIL sub_plain got %h/%b want 0200/00", n_sum, n_ovf); else passed++;
  endtask

  task automatic test_sticky_clear();
    n_out_ready = 1'b1;
    n_clr = 1'b1;
    @(negedge clk);
    n_clr = 1'b0;
    checks++; if (n_sticky !== 2'b00) $display("FAIL sticky_clr0 got %b want 00", n_sticky); else passed++;
    issue_n(2'b01, 16'h0080, 16'h0080);
    @(negedge clk);
    checks++; if (n_out_valid !== 1'b1 || n_sum !== 16'h0080 || n_ovf !== 2'b01) $display("FAIL sticky_beat got v=%b %h/%b want 1 0080/01", n_out_valid, n_sum, n_ovf); else passed++;
    n_clr = 1'b1;
    @(negedge clk);
    n_clr = 1'b0;
    checks++; if (n_sticky !== 2'b01) $display("FAIL sticky_set_wins got %b want 01", n_sticky); else passed++;
    n_clr = 1'b1;
    @(negedge clk);
    n_clr = 1'b0;
    checks++; if (n_sticky !== 2'b00) $display("FAIL sticky_clr1 got %b want 00", n_sticky); else passed++;
  endtask

  task automatic test_back_to_back();
    int sent = 0;
    int got = 0;
    logic stall_prev = 1'b0;
    logic [15:0] held = '0;
    for (int c = 0; c < 40; c++) begin
      n_out_ready = (c < 8) ? (c % 2 == 0) : ((c < 13) ? 1'b0 : 1'b1);
      n_in_valid  = (sent < 8);
      n_op = 2'b00;
      n_a  = 16'(16'h0101 * sent);
      n_b  = 16'h0101;
      #1;
      if (stall_prev) begin
        checks++; if (n_sum !== held) $display("FAIL b2b_stall_hold got %h want %h", n_sum, held); else passed++;
      end
      if (n_out_valid && !n_out_ready) begin
        checks++; if (n_in_ready !== 1'b0) $display("FAIL b2b_in_ready_full got %b want 0", n_in_ready); else passed++;
        stall_prev = 1'b1;
        held = n_sum;
      end else begin
        stall_prev = 1'b0;
      end
      if (n_out_valid && n_out_ready) begin
        checks++;
        if (got >= 8) $display("FAIL b2b_extra_beat got %h want none", n_sum);
        else if (n_sum !== 16'(16'h0101 * (got + 1))) $display("FAIL b2b_order got %h want %h", n_sum, 16'(16'h0101 * (got + 1)));
        else passed++;
        got++;
      end
      if (n_in_valid && n_in_ready) sent++;
      @(negedge clk);
    end
    n_in_valid = 1'b0;
    checks++; if (got != 8 || sent != 8) $display("FAIL b2b_count got %0d/%0d want 8/8", got, sent); else passed++;
  endtask

  task automatic test_reset_midflight();
    n_out_ready = 1'b1;
    n_op = 2'b01; n_a = 16'h7F80; n_b = 16'h0180; n_in_valid = 1'b1;
    @(negedge clk);
    n_a = 16'h7F7F; n_b = 16'h0101;
    @(negedge clk);
    n_in_valid = 1'b0;
    checks++; if (n_out_valid !== 1'b1) $display("FAIL mid_inflight got %b want 1", n_out_valid); else passed++;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    checks++; if (n_out_valid !== 1'b0) $display("FAIL mid_rst_valid got %b want 0", n_out_valid); else passed++;
    checks++; if (n_sticky !== 2'b00) $display("FAIL mid_rst_sticky got %b want 00", n_sticky); else passed++;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      checks++; if (n_out_valid !== 1'b0) $display("FAIL mid_no_ghost got %b want 0", n_out_valid); else passed++;
    end
  endtask

  task automatic test_wide();
    w_out_ready = 1'b1;
    issue_w(2'b01, 64'h7FFF_8000_1234_FFFF, 64'h0001_8000_1111_0001);
    @(negedge clk);
    checks++; if (w_sum !== 64'h7FFF_8000_2345_0000 || w_ovf !== 4'b1100) $display("FAIL wide_ssat got %h/%b want 7fff800023450000/1100", w_sum, w_ovf); else passed++;
    issue_w(2'b10, 64'hF000_0001_FFFF_8000, 64'h2000_0002_0001_7FFF);
    @(negedge clk);
    checks++; if (w_sum !== 64'hFFFF_0003_FFFF_FFFF || w_ovf !== 4'b1010) $display("FAIL wide_usat got %h/%b want ffff0003ffffffff/1010", w_sum, w_ovf); else passed++;
    issue_w(2'b11, 64'h8000_0005_7FFF_0000, 64'h0001_0007_FFFF_8000);
    @(negedge clk);
    checks++; if (w_sum !== 64'h8000_FFFE_7FFF_7FFF || w_ovf !== 4'b1011) $display("FAIL wide_sub got %h/%b want 8000fffe7fff7fff/1011", w_sum, w_ovf); else passed++;
    @(negedge clk);
    checks++; if (w_sticky !== 4'b1111) $display("FAIL wide_sticky got %b want 1111", w_sticky); else passed++;
  endtask

  initial begin
    rst = 1'b1;
    n_in_valid = 1'b0; n_out_ready = 1'b0; n_clr = 1'b0; n_op = 2'b00; n_a = '0; n_b = '0;
    w_in_valid = 1'b0; w_out_ready = 1'b0; w_clr = 1'b0; w_op = 2'b00; w_a = '0; w_b = '0;
    test_reset();
    test_add_ssat();
    test_usat_wrap();
    test_sub_ssat();
    test_sticky_clear();
    test_back_to_back();
    test_reset_midflight();
    test_wide();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL watchdog got timeout want completion");
    $fatal(1, "timeout");
  end

endmodule
